// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 (x^7 + x^6 + 1) receive checker with lock tracking
// and a saturating bit-error counter.
module prbs7_checker #(
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_ERRS  = 3,
  parameter int CNT_W      = 16
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_ERRS);

  state_t           state_q;
  logic [6:0]       sr_q;
  logic [2:0]       fill_q;
  logic [7:0]       match_cnt_q;
  logic [3:0]       consec_err_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [CNT_W-1:0] err_count_q;

  logic       pred;
  logic       search_match;
  logic       lock_miss;
  logic [7:0] match_inc;
  logic [3:0] err_inc;
  logic       cnt_sat;

  always_comb begin
    pred         = sr_q[6] ^ sr_q[5];
    // An all-zero register predicts zero forever, so it must never count as a match.
    search_match = (bit_in == pred) && (sr_q != 7'd0);
    lock_miss    = (bit_in != pred);
    match_inc    = match_cnt_q + 8'd1;
    err_inc      = consec_err_q + 4'd1;
    cnt_sat      = &err_count_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q      <= SEARCH;
      sr_q         <= 7'd0;
      fill_q       <= 3'd0;
      match_cnt_q  <= 8'd0;
      consec_err_q <= 4'd0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bit_valid) begin
        case (state_q)
          SEARCH: begin
            sr_q <= {sr_q[5:0], bit_in};
            if (fill_q != 3'd7) begin
              fill_q <= fill_q + 3'd1;
            end else if (search_match) begin
              if (match_inc == LOCK_C) begin
                state_q      <= LOCKED;
                locked_q     <= 1'b1;
                match_cnt_q  <= 8'd0;
                consec_err_q <= 4'd0;
              end else begin
                match_cnt_q <= match_inc;
              end
            end else begin
              match_cnt_q <= 8'd0;
            end
          end
          LOCKED: begin
            // Flywheel: the local reference advances on its own prediction.
            sr_q <= {sr_q[5:0], pred};
            if (lock_miss) begin
              err_pulse_q <= 1'b1;
              if (!cnt_sat) err_count_q <= err_count_q + CNT_W'(1);
              if (err_inc == LOSS_C) begin
                state_q      <= SEARCH;
                locked_q     <= 1'b0;
                fill_q       <= 3'd0;
                match_cnt_q  <= 8'd0;
                consec_err_q <= 4'd0;
              end else begin
                consec_err_q <= err_inc;
              end
            end else begin
              consec_err_q <= 4'd0;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
      // Clear overrides any increment made in the same cycle.
      if (clr_count) err_count_q <= '0;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: lock point, single error, loss/relock,
// all-zero stream, gapped valid, saturation, clear priority and reset.
module tb_prbs7_checker;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             clr_count = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  int tests = 0;
  int fails = 0;

  logic [6:0] gen_q;
  int         pulses;
  int         lock_seen;
  int         lock_drops;

  prbs7_checker #(
    .LOCK_COUNT(16),
    .LOSS_ERRS (3),
    .CNT_W     (CNT_W)
  ) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .clr_count(clr_count),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  task automatic next_bit(output logic b);
    b     = gen_q[6] ^ gen_q[5];
    gen_q = {gen_q[5:0], b};
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic send(input logic b, input logic v, input logic c, input logic r);
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    clr_count = c;
    rst       = r;
    @(posedge clk);
    #1;
    if (err_pulse) pulses++;
  endtask

  task automatic clean_bits(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      send(b, 1'b1, 1'b0, 1'b0);
      if (!locked) lock_drops++;
    end
  endtask

  task automatic error_bit(input logic clr);
    logic b;
    next_bit(b);
    send(~b, 1'b1, clr, 1'b0);
  endtask

  task automatic do_reset();
    send(1'b0, 1'b0, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b0, 1'b1);
    gen_q = 7'h01;
  endtask

  initial begin
    logic b;
    int   nvalid;

    // Reset state
    do_reset();
    check("rst_locked", 32'(locked), 0);
    check("rst_pulse", 32'(err_pulse), 0);
    check("rst_count", 32'(err_count), 0);

    // Clean stream: lock on valid bit 23, then 300 bits total with no errors
    pulses = 0;
    lock_seen = 0;
    for (int i = 1; i <= 23; i++) begin
      next_bit(b);
      send(b, 1'b1, 1'b0, 1'b0);
      if (i == 22) check("clean_unlocked_at_22", 32'(locked), 0);
      if (i == 23) check("clean_locked_at_23", 32'(locked), 1);
    end
    lock_drops = 0;
    clean_bits(277);
    check("clean_lock_drops", 32'(lock_drops), 0);
    check("clean_pulses", 32'(pulses), 0);
    check("clean_count", 32'(err_count), 0);

    // Single error
    pulses = 0;
    error_bit(1'b0);
    check("single_pulse", 32'(err_pulse), 1);
    check("single_count", 32'(err_count), 1);
    check("single_locked", 32'(locked), 1);
    clean_bits(1);
    check("single_pulse_gone", 32'(err_pulse), 0);
    lock_drops = 0;
    clean_bits(30);
    check("single_total_pulses", 32'(pulses), 1);
    check("single_count_hold", 32'(err_count), 1);
    check("single_lock_drops", 32'(lock_drops), 0);

    // Clear on an idle cycle, then loss and relock
    send(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_idle_count", 32'(err_count), 0);
    check("idle_locked", 32'(locked), 1);
    pulses = 0;
    error_bit(1'b0);
    check("loss_e1_locked", 32'(locked), 1);
    error_bit(1'b0);
    check("loss_e2_locked", 32'(locked), 1);
    error_bit(1'b0);
    check("loss_e3_locked", 32'(locked), 0);
    check("loss_e3_pulse", 32'(err_pulse), 1);
    check("loss_pulses", 32'(pulses), 3);
    check("loss_count", 32'(err_count), 3);
    for (int i = 1; i <= 23; i++) begin
      next_bit(b);
      send(b, 1'b1, 1'b0, 1'b0);
      if (i == 22) check("relock_unlocked_at_22", 32'(locked), 0);
      if (i == 23) check("relock_locked_at_23", 32'(locked), 1);
    end
    check("relock_count", 32'(err_count), 3);

    // All-zero input never locks
    do_reset();
    pulses = 0;
    lock_seen = 0;
    for (int i = 0; i < 200; i++) begin
      send(1'b0, 1'b1, 1'b0, 1'b0);
      if (locked) lock_seen++;
    end
    check("zero_lock_seen", 32'(lock_seen), 0);
    check("zero_count", 32'(err_count), 0);
    check("zero_pulses", 32'(pulses), 0);

    // Gapped valid: lock point counted in valid bits
    do_reset();
    pulses = 0;
    lock_seen = 0;
    nvalid = 0;
    while (nvalid < 100) begin
      if ($urandom_range(0, 1) == 0) begin
        send(1'b1, 1'b0, 1'b0, 1'b0);
        if (err_pulse) lock_seen++;
      end else begin
        next_bit(b);
        send(b, 1'b1, 1'b0, 1'b0);
        nvalid++;
        if (nvalid == 22) check("gap_unlocked_at_22", 32'(locked), 0);
        if (nvalid == 23) check("gap_locked_at_23", 32'(locked), 1);
      end
    end
    check("gap_locked_end", 32'(locked), 1);
    check("gap_pulses", 32'(pulses), 0);
    check("gap_idle_pulse", 32'(lock_seen), 0);

    // Saturation with 20 isolated errors
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      error_bit(1'b0);
      clean_bits(3);
      if (i == 14) check("sat_count_at_15", 32'(err_count), 15);
    end
    check("sat_count", 32'(err_count), 15);
    check("sat_pulses", 32'(pulses), 20);
    check("sat_locked", 32'(locked), 1);

    // Clear together with an error: clear wins, pulse still fires
    error_bit(1'b1);
    check("clr_err_count", 32'(err_count), 0);
    check("clr_err_pulse", 32'(err_pulse), 1);
    clean_bits(3);

    // Reset while locked, with a valid bad bit in the same cycle
    error_bit(1'b0);
    check("pre_rst_count", 32'(err_count), 1);
    clean_bits(2);
    check("pre_rst_locked", 32'(locked), 1);
    next_bit(b);
    send(~b, 1'b1, 1'b0, 1'b1);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_pulse", 32'(err_pulse), 0);
    check("midrst_count", 32'(err_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
